// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control sequencer.
// Optional JAL support is selected with the JAL_EN macro.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD,
    MEM_WB, MEM_WR, WB_R, WB_I, BRANCH, JUMP
  } stateT;

  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] ORI    = 6'h0d;
  localparam logic [5:0] ANDI   = 6'h0c;
  localparam logic [5:0] LUI    = 6'h0f;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] SW     = 6'h2b;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] BNE    = 6'h05;
  localparam logic [5:0] J      = 6'h02;
  localparam logic [5:0] JAL    = 6'h03;

  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_AND   = 3'b110;
  localparam logic [2:0] ALU_LUI   = 3'b010;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       regDst;
    logic       memtoReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic [1:0] pcSource;
    logic       link;
  } ctrlT;

  // Static (Moore) control lines for a state; op is the opcode latched in DECODE.
  function automatic ctrlT decodeCtrl(stateT s, logic [5:0] op);
    ctrlT c;
    c = '0;
    case (s)
      FETCH: begin
        c.memRead = 1'b1;
        c.aluSrcB = SRCB_FOUR;
        c.aluOp   = ALU_ADD;
        c.pcSource = PC_ALU;
      end
      DECODE: begin
        c.aluSrcB = SRCB_IMMSH2;
        c.aluOp   = ALU_ADD;
      end
      EXEC_R: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_RT;
        c.aluOp   = ALU_RTYPE;
      end
      EXEC_I: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_IMM;
        case (op)
          ORI:     c.aluOp = ALU_OR;
          ANDI:    c.aluOp = ALU_AND;
          LUI:     c.aluOp = ALU_LUI;
          default: c.aluOp = ALU_ADD;
        endcase
      end
      MEM_ADDR: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_IMM;
        c.aluOp   = ALU_ADD;
      end
      MEM_RD: begin
        c.iorD    = 1'b1;
        c.memRead = 1'b1;
      end
      MEM_WR: begin
        c.iorD     = 1'b1;
        c.memWrite = 1'b1;
      end
      MEM_WB: begin
        c.memtoReg = 1'b1;
        c.regWrite = 1'b1;
      end
      WB_R: begin
        c.regDst   = 1'b1;
        c.regWrite = 1'b1;
      end
      WB_I: c.regWrite = 1'b1;
      BRANCH: begin
        c.aluSrcA  = 1'b1;
        c.aluSrcB  = SRCB_RT;
        c.aluOp    = ALU_SUB;
        c.pcSource = PC_ALUOUT;
      end
      JUMP: begin
        c.pcSource = PC_JUMP;
`ifdef JAL_EN
        if (op == JAL) begin
          c.link     = 1'b1;
          c.regWrite = 1'b1;
        end
`endif
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_retire_counter.sv
// Retired-instruction counter: 32-bit wrapping increment with synchronous active-low clear.
module retire_counter (
  input  logic        clk,
  input  logic        clearN,
  input  logic        en,
  output logic [31:0] count
);

  always_ff @(posedge clk) begin
    if (!clearN)
      count <= '0;
    else if (en)
      count <= count + 32'd1;
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control sequencer with memory-ready stalls and retire counting.
// Define JAL_EN to accept JAL (opcode 0x03) and drive Link in the JUMP state.
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  OP,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUOp,
  output logic [1:0]  PCSource,
  output logic        PCWrite,
  output logic        Link,
  output logic        illegal_op,
  output logic [31:0] retired
);
  import mips_ctrl_pkg::*;

  stateT      state, nextState;
  logic [5:0] opReg, nextOp;
  ctrlT       ctrlQ, ctrlOut;
  logic       retireNow;

  always_comb begin
    nextState = state;
    case (state)
      FETCH:    if (mem_ready) nextState = DECODE;
      DECODE: begin
        case (OP)
          R_TYPE:               nextState = EXEC_R;
          ADDI, ORI, ANDI, LUI: nextState = EXEC_I;
          LW, SW:               nextState = MEM_ADDR;
          BEQ, BNE:             nextState = BRANCH;
          J:                    nextState = JUMP;
`ifdef JAL_EN
          JAL:                  nextState = JUMP;
`endif
          default:              nextState = FETCH;
        endcase
      end
      EXEC_R:   nextState = WB_R;
      EXEC_I:   nextState = WB_I;
      MEM_ADDR: nextState = (opReg == LW) ? MEM_RD : MEM_WR;
      MEM_RD:   if (mem_ready) nextState = MEM_WB;
      MEM_WR:   if (mem_ready) nextState = FETCH;
      default:  nextState = FETCH;
    endcase
  end

  assign nextOp = (state == DECODE) ? OP : opReg;

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH;
      opReg <= R_TYPE;
      ctrlQ <= decodeCtrl(FETCH, R_TYPE);
    end else begin
      state <= nextState;
      opReg <= nextOp;
      ctrlQ <= decodeCtrl(nextState, nextOp);
    end
  end

  assign ctrlOut  = reset ? ctrlQ : decodeCtrl(FETCH, R_TYPE);
  assign IorD     = ctrlOut.iorD;
  assign MemRead  = ctrlOut.memRead;
  assign MemWrite = ctrlOut.memWrite;
  assign RegDst   = ctrlOut.regDst;
  assign MemtoReg = ctrlOut.memtoReg;
  assign RegWrite = ctrlOut.regWrite;
  assign ALUSrcA  = ctrlOut.aluSrcA;
  assign ALUSrcB  = ctrlOut.aluSrcB;
  assign ALUOp    = ctrlOut.aluOp;
  assign PCSource = ctrlOut.pcSource;
  assign Link     = ctrlOut.link;

  assign IRWrite    = reset && (state == FETCH) && mem_ready;
  assign illegal_op = reset && (state == DECODE) && (nextState == FETCH);

  // PC load qualifies the state with the handshake or branch outcome of this cycle.
  always_comb begin
    PCWrite = 1'b0;
    if (reset) begin
      case (state)
        FETCH:   PCWrite = mem_ready;
        BRANCH:  PCWrite = (opReg == BNE) ? ~Zero : Zero;
        JUMP:    PCWrite = 1'b1;
        default: PCWrite = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (state)
      WB_R, WB_I, MEM_WB, BRANCH, JUMP: retireNow = 1'b1;
      MEM_WR:                           retireNow = mem_ready;
      default:                          retireNow = 1'b0;
    endcase
  end

  retire_counter retireCounter (
    .clk    (clk),
    .clearN (reset),
    .en     (retireNow),
    .count  (retired)
  );

endmodule
